// File: rtl/ifetch_queue.sv
// Instruction fetch stage: PC generation, 1-cycle synchronous imem reads and a
// DEPTH-entry instruction queue presented to decode over valid/ready.
module ifetch_queue #(
   parameter int PC_W = 16,
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32,
   parameter int J_W = 26,
   parameter int B_W = 16,
   parameter int DEPTH = 2,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              run_i,
   input  logic              restart_i,
   input  logic              j_valid_i,
   input  logic [J_W-1:0]    j_addr_i,
   input  logic              b_valid_i,
   input  logic [B_W-1:0]    b_off_i,
   input  logic [PC_W-1:0]   redir_pc_i,
   output logic              imem_en_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [DATA_W-1:0] imem_rdata_i,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [DATA_W-1:0] instr_o,
   output logic [PC_W-1:0]   instr_pc_o,
   output logic [PC_W-1:0]   pc_plus1_o,
   output logic              range_err_o
);

   localparam int CW = $clog2(DEPTH + 1) + 1;

   logic [PC_W-1:0]   pc_q, pc_d;
   logic              live_q, live_d;
   logic              epoch_q, epoch_d;
   logic              inflight_q, inflight_d;
   logic              tag_epoch_q, tag_epoch_d;
   logic [PC_W-1:0]   tag_pc_q, tag_pc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] dat_q [DEPTH];
   logic [DATA_W-1:0] dat_d [DEPTH];
   logic [PC_W-1:0]   epc_q [DEPTH];
   logic [PC_W-1:0]   epc_d [DEPTH];
   logic [PC_W-1:0]   pp1_q, pp1_d;

   logic              redir_s, pop_s, room_s, over_s, try_s, issue_s, trap_s, push_s;
   logic [CW-1:0]     occ_s, widx_s;
   logic [PC_W-1:0]   boff_s;

   // Issue / trap / return decisions for the current cycle
   always_comb begin
      redir_s = restart_i | j_valid_i | b_valid_i;
      pop_s   = valid_q & instr_ready_i;
      // in-flight read is counted against capacity so it always has a slot
      occ_s   = cnt_q + CW'(inflight_q) - CW'(pop_s);
      room_s  = (occ_s < CW'(DEPTH));
      over_s  = |(pc_q >> ADDR_W);
      try_s   = live_q & run_i & ~redir_s & room_s;
      issue_s = try_s & ~over_s;
      trap_s  = try_s & over_s;
      push_s  = inflight_q & (tag_epoch_q == epoch_q) & ~redir_s;
      boff_s  = PC_W'($signed(b_off_i));
   end

   // PC, epoch and in-flight tag next state
   always_comb begin
      live_d      = 1'b1;
      epoch_d     = epoch_q ^ redir_s;
      inflight_d  = issue_s;
      tag_pc_d    = issue_s ? pc_q : tag_pc_q;
      tag_epoch_d = issue_s ? epoch_q : tag_epoch_q;
      if (restart_i) begin
         pc_d = RESET_PC;
      end else if (j_valid_i) begin
         pc_d = PC_W'(j_addr_i);
      end else if (b_valid_i) begin
         pc_d = redir_pc_i + PC_W'(1'b1) + boff_s;
      end else if (trap_s) begin
         pc_d = RESET_PC;
      end else if (issue_s) begin
         pc_d = pc_q + PC_W'(1'b1);
      end else begin
         pc_d = pc_q;
      end
   end

   // Shift-style queue: entry 0 is always the head, so outputs come straight from flops
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         dat_d[i] = dat_q[i];
         epc_d[i] = epc_q[i];
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         dat_d[i] = pop_s ? dat_q[i+1] : dat_q[i];
         epc_d[i] = pop_s ? epc_q[i+1] : epc_q[i];
      end
      widx_s = cnt_q - CW'(pop_s);
      for (int i = 0; i < DEPTH; i++) begin
         dat_d[i] = (push_s && (widx_s == CW'(i))) ? imem_rdata_i : dat_d[i];
         epc_d[i] = (push_s && (widx_s == CW'(i))) ? tag_pc_q : epc_d[i];
      end
      cnt_d   = redir_s ? {CW{1'b0}} : (cnt_q + CW'(push_s) - CW'(pop_s));
      valid_d = (cnt_d != {CW{1'b0}});
      pp1_d   = epc_d[0] + PC_W'(1'b1);
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q        <= RESET_PC;
         live_q      <= 1'b0;
         epoch_q     <= 1'b0;
         inflight_q  <= 1'b0;
         tag_epoch_q <= 1'b0;
         tag_pc_q    <= {PC_W{1'b0}};
         cnt_q       <= {CW{1'b0}};
         valid_q     <= 1'b0;
         pp1_q       <= {PC_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            dat_q[i] <= {DATA_W{1'b0}};
            epc_q[i] <= {PC_W{1'b0}};
         end
      end else begin
         pc_q        <= pc_d;
         live_q      <= live_d;
         epoch_q     <= epoch_d;
         inflight_q  <= inflight_d;
         tag_epoch_q <= tag_epoch_d;
         tag_pc_q    <= tag_pc_d;
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         pp1_q       <= pp1_d;
         for (int i = 0; i < DEPTH; i++) begin
            dat_q[i] <= dat_d[i];
            epc_q[i] <= epc_d[i];
         end
      end
   end

   assign imem_en_o     = issue_s;
   assign imem_addr_o   = issue_s ? pc_q[ADDR_W-1:0] : {ADDR_W{1'b0}};
   assign range_err_o   = trap_s;
   assign instr_valid_o = valid_q;
   assign instr_o       = dat_q[0];
   assign instr_pc_o    = epc_q[0];
   assign pc_plus1_o    = pp1_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: per-cycle vector table for the start-up
// stream, scoreboard of expected {pc, instr} for every delivered instruction.
module tb_ifetch_queue;

   localparam int DEPTH = 2;
   localparam logic [15:0] MAX_PC = 16'h3FFF;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        run_i, restart_i, j_valid_i, b_valid_i, instr_ready_i;
   logic [25:0] j_addr_i;
   logic [15:0] b_off_i, redir_pc_i;
   logic        imem_en_o, instr_valid_o, range_err_o;
   logic [13:0] imem_addr_o;
   logic [31:0] imem_rdata_i = 32'h0;
   logic [31:0] instr_o;
   logic [15:0] instr_pc_o, pc_plus1_o;

   always #5 clk_i = ~clk_i;

   ifetch_queue dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i), .restart_i(restart_i),
      .j_valid_i(j_valid_i), .j_addr_i(j_addr_i), .b_valid_i(b_valid_i),
      .b_off_i(b_off_i), .redir_pc_i(redir_pc_i), .imem_en_o(imem_en_o),
      .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o), .pc_plus1_o(pc_plus1_o),
      .range_err_o(range_err_o)
   );

   // memory word n holds 0x1000 + n, one cycle read latency
   always_ff @(posedge clk_i) begin
      if (imem_en_o) imem_rdata_i <= 32'h0000_1000 + 32'(imem_addr_o);
   end

   typedef struct { logic [15:0] pc; logic [31:0] data; } exp_t;
   typedef struct {
      logic run; logic ready; logic en; logic [13:0] addr; logic valid; logic [15:0] pc;
   } vec_t;

   exp_t        sb[$];
   exp_t        e;
   vec_t        vecs[10];
   logic [15:0] exp_pc = 16'h0;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [15:0] redir_target();
      if (restart_i) return 16'h0000;
      else if (j_valid_i) return j_addr_i[15:0];
      else return redir_pc_i + 16'd1 + b_off_i;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_en"}, 32'(imem_en_o), 32'd0);
      chk({tag, "_addr"}, 32'(imem_addr_o), 32'd0);
      chk({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
      chk({tag, "_instr"}, instr_o, 32'd0);
      chk({tag, "_pc"}, 32'(instr_pc_o), 32'd0);
      chk({tag, "_pc1"}, 32'(pc_plus1_o), 32'd0);
      chk({tag, "_rerr"}, 32'(range_err_o), 32'd0);
   endtask

   // Scoreboard: predicts each issue address, queues its data, checks every accepted head
   initial begin
      forever begin
         @(negedge clk_i);
         if (!rst_n_i) begin
            sb.delete();
            exp_pc = 16'h0000;
         end else begin
            if (instr_valid_o && instr_ready_i) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_pop: got pc %h, expected no instruction", instr_pc_o);
               end else begin
                  e = sb.pop_front();
                  chk("pop_pc", 32'(instr_pc_o), 32'(e.pc));
                  chk("pop_instr", instr_o, e.data);
                  chk("pop_pc_plus1", 32'(pc_plus1_o), 32'(16'(e.pc + 16'd1)));
               end
            end
            if (restart_i || j_valid_i || b_valid_i) begin
               chk("redirect_no_issue", 32'(imem_en_o), 32'd0);
               sb.delete();
               exp_pc = redir_target();
            end else if (range_err_o) begin
               chk("trap_pc_over_max", 32'(exp_pc > MAX_PC), 32'd1);
               chk("trap_no_issue", 32'(imem_en_o), 32'd0);
               exp_pc = 16'h0000;
            end else if (imem_en_o) begin
               chk("issue_needs_run", 32'(run_i), 32'd1);
               chk("issue_in_range", 32'(exp_pc <= MAX_PC), 32'd1);
               chk("issue_addr", 32'(imem_addr_o), 32'(exp_pc[13:0]));
               sb.push_back('{pc: exp_pc, data: 32'h0000_1000 + 32'(exp_pc)});
               exp_pc = exp_pc + 16'd1;
               chk("outstanding_bound", 32'(sb.size() <= DEPTH + 1), 32'd1);
            end
         end
      end
   end

   initial begin
      rst_n_i = 1'b0; run_i = 1'b1; instr_ready_i = 1'b1; restart_i = 1'b0;
      j_valid_i = 1'b0; b_valid_i = 1'b0; j_addr_i = 26'h0; b_off_i = 16'h0;
      redir_pc_i = 16'h0;
      for (int i = 0; i < 10; i++) begin
         vecs[i] = '{run: 1'b1, ready: 1'b1, en: 1'b1, addr: 14'(i),
                     valid: (i >= 2), pc: 16'((i >= 2) ? i - 2 : 0)};
      end

      // reset state with run requested
      #2;
      chk_all_zero("reset");
      @(negedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // start-up stream: addresses from the first edge, data two cycles later
      for (int i = 0; i < 10; i++) begin
         cyc();
         run_i = vecs[i].run;
         instr_ready_i = vecs[i].ready;
         @(negedge clk_i);
         chk("t1_en", 32'(imem_en_o), 32'(vecs[i].en));
         chk("t1_addr", 32'(imem_addr_o), 32'(vecs[i].addr));
         chk("t1_valid", 32'(instr_valid_o), 32'(vecs[i].valid));
         if (vecs[i].valid) begin
            chk("t1_pc", 32'(instr_pc_o), 32'(vecs[i].pc));
            chk("t1_instr", instr_o, 32'h0000_1000 + 32'(vecs[i].pc));
            chk("t1_pc1", 32'(pc_plus1_o), 32'(vecs[i].pc) + 32'd1);
         end
      end

      // backpressure: head held, no new issue once outstanding slots are used
      cyc();
      instr_ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         chk("stall_valid", 32'(instr_valid_o), 32'd1);
         if (sb.size() > 0) begin
            chk("stall_head_pc", 32'(instr_pc_o), 32'(sb[0].pc));
         end else begin
            chk("stall_sb_nonempty", 32'(sb.size()), 32'd1);
         end
         chk("stall_no_issue", 32'(imem_en_o), 32'd0);
         if (k < 4) cyc();
      end
      cyc();
      instr_ready_i = 1'b1;
      repeat (6) cyc();

      // run_i low freezes issue
      run_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk("norun_no_issue", 32'(imem_en_o), 32'd0);
         cyc();
      end
      run_i = 1'b1;
      repeat (5) cyc();

      // branch back by 4 from pc 10 -> target 7
      b_valid_i = 1'b1; redir_pc_i = 16'd10; b_off_i = 16'hFFFC;
      cyc();
      b_valid_i = 1'b0;
      @(negedge clk_i);
      chk("br_flush_valid", 32'(instr_valid_o), 32'd0);
      chk("br_target_en", 32'(imem_en_o), 32'd1);
      chk("br_target_addr", 32'(imem_addr_o), 32'h7);
      repeat (4) cyc();

      // jump wins over branch
      j_valid_i = 1'b1; b_valid_i = 1'b1; j_addr_i = 26'h20;
      cyc();
      j_valid_i = 1'b0; b_valid_i = 1'b0;
      @(negedge clk_i);
      chk("jb_flush_valid", 32'(instr_valid_o), 32'd0);
      chk("jb_target_addr", 32'(imem_addr_o), 32'h20);
      repeat (4) cyc();

      // top of memory then range trap
      j_valid_i = 1'b1; j_addr_i = 26'h3FFE;
      cyc();
      j_valid_i = 1'b0;
      @(negedge clk_i);
      chk("top_addr0", 32'(imem_addr_o), 32'h3FFE);
      cyc();
      @(negedge clk_i);
      chk("top_addr1", 32'(imem_addr_o), 32'h3FFF);
      cyc();
      @(negedge clk_i);
      chk("trap_pulse", 32'(range_err_o), 32'd1);
      chk("trap_en", 32'(imem_en_o), 32'd0);
      cyc();
      @(negedge clk_i);
      chk("trap_pulse_end", 32'(range_err_o), 32'd0);
      chk("trap_next_en", 32'(imem_en_o), 32'd1);
      chk("trap_next_addr", 32'(imem_addr_o), 32'h0);
      repeat (5) cyc();

      // restart with queue occupied and a read returning
      instr_ready_i = 1'b0; restart_i = 1'b1;
      cyc();
      restart_i = 1'b0; instr_ready_i = 1'b1;
      @(negedge clk_i);
      chk("rst_flush_valid", 32'(instr_valid_o), 32'd0);
      chk("rst_addr", 32'(imem_addr_o), 32'h0);
      cyc();
      cyc();
      @(negedge clk_i);
      chk("rst_first_valid", 32'(instr_valid_o), 32'd1);
      chk("rst_first_pc", 32'(instr_pc_o), 32'h0);
      repeat (4) cyc();

      // asynchronous reset between edges
      #2;
      rst_n_i = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(posedge clk_i);
      @(negedge clk_i);
      chk("async_rst_hold", 32'(instr_valid_o), 32'd0);
      rst_n_i = 1'b1;
      cyc();
      @(negedge clk_i);
      chk("post_rst_en", 32'(imem_en_o), 32'd1);
      chk("post_rst_addr", 32'(imem_addr_o), 32'h0);
      repeat (6) cyc();

      // drain: everything issued must have been delivered
      run_i = 1'b0;
      repeat (6) cyc();
      @(negedge clk_i);
      chk("drain_sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Generates a word-addressed PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, with their PCs, in a DEPTH-entry queue.
- Presents them to decode over a valid/ready handshake. Supports jump/branch redirect with flush, synchronous restart, and PC range trapping.

Parameters:
PC_W, 16, width of the internal PC (word address).
ADDR_W, 14, instruction memory address width; MAX_PC = 2^ADDR_W - 1.
DATA_W, 32, instruction width.
J_W, 26, jump target field width.
B_W, 16, branch offset width (two's complement, in words).
DEPTH, 2, instruction queue entries; power of two, at least 2.
RESET_PC, 0, PC value after reset, restart or range trap.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_n_i  in  1  asynchronous active-low reset.
run_i  in  1  fetch enable; 0 = no new issue (queue still drains).
restart_i  in  1  synchronous restart: flush everything, PC <= RESET_PC.
j_valid_i  in  1  jump redirect.
j_addr_i  in  J_W  jump target, absolute word address.
b_valid_i  in  1  branch-taken redirect.
b_off_i  in  B_W  branch offset.
redir_pc_i  in  PC_W  PC of the redirecting instruction.
imem_en_o  out  1  memory read strobe.
imem_addr_o  out  ADDR_W  memory read address.
imem_rdata_i  in  DATA_W  read data, valid the cycle after imem_en_o.
instr_valid_o  out  1  queue head valid.
instr_ready_i  in  1  decode accepts head.
instr_o  out  DATA_W  head instruction.
instr_pc_o  out  PC_W  head PC.
pc_plus1_o  out  PC_W  instr_pc_o + 1, wrapping mod 2^PC_W.
range_err_o  out  1  one-cycle pulse on PC range trap.

Behaviour:
Reset
- Async assert: pc_q = RESET_PC, queue empty, inflight = 0, epoch = 0.
- All outputs 0.
- Release takes effect at the next clock edge.

Pop
- Occurs when instr_valid_o && instr_ready_i.
- instr_valid_o, instr_o and instr_pc_o are registered from the queue head.
- Head data is held stable while valid && !ready.

Issue
- Condition: run_i && !restart_i && !j_valid_i && !b_valid_i && pc_q <= MAX_PC && (occupancy + inflight - pop) < DEPTH.
- On issue: imem_en_o = 1, imem_addr_o = pc_q[ADDR_W-1:0], pc_q <= pc_q + 1.
- Issue does not depend on the registered state of the returned data.
- The issue tag records {epoch, pc_q}.
- Throughput: 1 instruction/cycle sustained when ready is held high, DEPTH >= 2.

Return
- The cycle after issue, inflight = 1.
- If the tag epoch equals the current epoch, push {imem_rdata_i, tag pc}.
- Otherwise discard the data.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.

Redirect priority: restart_i > j_valid_i > b_valid_i.
- restart_i: pc_q <= RESET_PC.
- j_valid_i: pc_q <= zero-extended or truncated j_addr_i to PC_W.
- b_valid_i: pc_q <= redir_pc_i + 1 + sext(b_off_i), modulo 2^PC_W.
- Any redirect: queue flushed (instr_valid_o = 0 next cycle), epoch toggles, no issue that cycle, the in-flight response is discarded.
- A pop in the redirect cycle is still a valid accept.
- First fetch of the target occurs the cycle after the redirect.

Range trap
- Triggered when pc_q > MAX_PC and issue is otherwise allowed: no issue, pc_q <= RESET_PC, range_err_o = 1 for one cycle.
- The queue is not flushed.

General
- run_i = 0 freezes pc_q but does not flush.
- Redirect with run_i = 0 still updates pc_q and flushes.
- Arithmetic is unsigned modulo 2^PC_W, except that b_off_i is sign-extended.

Test Plan:
- Reset, run_i = 1, ready = 1, memory word n = 0x1000+n → imem_addr_o 0,1,2,… from the first edge; instr_o 0x1000,0x1001,… with instr_pc_o 0,1,…; one per cycle after 2-cycle latency; pc_plus1_o = instr_pc_o+1.
- ready = 0 for 5 cycles from PC 3 → at most DEPTH+1 outstanding; head held at pc 3; release ready → pcs 3,4,5… with no gaps or duplicates.
- b_valid_i with redir_pc_i = 10, b_off_i = 0xFFFC → queue flushed, in-flight word dropped, next issued address 7; j_valid_i and b_valid_i together with j_addr_i = 0x20 → next address 0x20.
- j_addr_i = 0x3FFE, run → addresses 0x3FFE, 0x3FFF; pc_q = 0x4000 → range_err_o pulse, next address RESET_PC = 0.
- restart_i asserted while queue is full and a read is in flight → instr_valid_o 0 next cycle, next address 0, no stale data delivered.
- rst_n_i asserted mid-stream between clock edges → outputs 0 immediately; after release, fetch restarts at RESET_PC.
